// File: rtl/ascon_aead128_pkg.sv
// Shared types and constants for the Ascon-AEAD128 datapath: round index,
// permutation modes, the 320-bit state layout, FSM states and the S-box.
package ascon_aead128_pkg;

    typedef logic [3:0] round;

    localparam logic P12_MODE = 1'b0;
    localparam logic P8_MODE  = 1'b1;

    localparam round P12_INIT = 4'h4;
    localparam round P8_INIT  = 4'h8;
    localparam round RND_LAST = 4'hF;

    // x0 occupies the most significant word, x4 the least.
    typedef struct packed {
        logic [63:0] x0;
        logic [63:0] x1;
        logic [63:0] x2;
        logic [63:0] x3;
        logic [63:0] x4;
    } ascon_state_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } perm_state_e;

    // Index 0 is the leftmost entry; the index is {x0,x1,x2,x3,x4} of one bit slice.
    localparam logic [0:31][4:0] SBOX = {
        5'h04, 5'h0B, 5'h1F, 5'h14, 5'h1A, 5'h15, 5'h09, 5'h02,
        5'h1B, 5'h05, 5'h08, 5'h12, 5'h1D, 5'h03, 5'h06, 5'h1C,
        5'h1E, 5'h13, 5'h07, 5'h0E, 5'h00, 5'h0D, 5'h11, 5'h18,
        5'h10, 5'h0C, 5'h01, 5'h19, 5'h16, 5'h0A, 5'h0F, 5'h17
    };

    // Round constant {15-j, j} with j = rnd - 4; in four bits 15-j is simply ~j.
    function automatic logic [7:0] round_const(input round rnd);
        round j;
        j = rnd - P12_INIT;
        return {~j, j};
    endfunction

    function automatic logic [63:0] ror64(input logic [63:0] x, input int unsigned n);
        return (x >> n) | (x << (64 - n));
    endfunction

endpackage

// File: rtl/ascon_permutation_round.sv
// One Ascon round: constant addition, 5-bit S-box layer, linear diffusion.
// Purely combinational so it can be reused in unrolled variants.
module ascon_round
    import ascon_aead128_pkg::*;
(
    input  ascon_state_t i_state,
    input  logic [7:0]   i_rc,
    output ascon_state_t o_state
);

    ascon_state_t w_add;
    ascon_state_t w_sub;

    // Add the round constant to x2, then substitute every bit slice through the S-box.
    always_comb begin
        logic [4:0] v_sin;
        logic [4:0] v_sout;
        // NOTE: every comb output gets a full default before any conditional or
        // partial write, so no path can leave it holding a value (no latch).
        v_sin    = '0;
        v_sout   = '0;
        w_add    = i_state;
        w_add.x2 = i_state.x2 ^ {56'h0, i_rc};
        w_sub    = '0;
        for (int b = 0; b < 64; b++) begin
            v_sin        = {w_add.x0[b], w_add.x1[b], w_add.x2[b], w_add.x3[b], w_add.x4[b]};
            v_sout       = SBOX[v_sin];
            w_sub.x0[b]  = v_sout[4];
            w_sub.x1[b]  = v_sout[3];
            w_sub.x2[b]  = v_sout[2];
            w_sub.x3[b]  = v_sout[1];
            w_sub.x4[b]  = v_sout[0];
        end
    end

    assign o_state.x0 = w_sub.x0 ^ ror64(w_sub.x0, 19) ^ ror64(w_sub.x0, 28);
    assign o_state.x1 = w_sub.x1 ^ ror64(w_sub.x1, 61) ^ ror64(w_sub.x1, 39);
    assign o_state.x2 = w_sub.x2 ^ ror64(w_sub.x2, 1)  ^ ror64(w_sub.x2, 6);
    assign o_state.x3 = w_sub.x3 ^ ror64(w_sub.x3, 10) ^ ror64(w_sub.x3, 17);
    assign o_state.x4 = w_sub.x4 ^ ror64(w_sub.x4, 7)  ^ ror64(w_sub.x4, 41);

endmodule

// File: rtl/ascon_permutation.sv
// Iterative Ascon permutation: one round per clock, p12 or p8 selected at
// acceptance, result held in DONE until the downstream handshake.
module ascon_permutation
    import ascon_aead128_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         mode,
    input  logic [319:0] state_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [319:0] state_out
);

    perm_state_e  r_state;
    perm_state_e  w_state_nxt;
    ascon_state_t r_data;
    ascon_state_t w_round_out;
    round         r_rnd;
    logic [7:0]   w_rc;
    logic         w_accept;

    assign w_accept = (r_state == IDLE) && in_valid;
    assign w_rc     = round_const(r_rnd);

    ascon_round u_round (
        .i_state (r_data),
        .i_rc    (w_rc),
        .o_state (w_round_out)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments so all registers update from pre-edge values.
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state decode: accept in IDLE, leave RUN after round 15, release DONE on handshake.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (in_valid)            w_state_nxt = RUN;
            RUN:     if (r_rnd == RND_LAST)   w_state_nxt = DONE;
            DONE:    if (out_ready)           w_state_nxt = IDLE;
            default:                          w_state_nxt = IDLE;
        endcase
    end

    // State and round index: load on acceptance, advance one round per RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the 320-bit state register is reset on purpose: state_out must read
        // zero after reset and an aborted permutation must not remain visible.
        if (!rst_n) begin
            r_data <= '0;
            r_rnd  <= P12_INIT;
        end else if (w_accept) begin
            r_data <= state_in;
            r_rnd  <= (mode == P8_MODE) ? P8_INIT : P12_INIT;
        end else if (r_state == RUN) begin
            r_data <= w_round_out;
            if (r_rnd != RND_LAST) r_rnd <= r_rnd + 4'd1;
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign state_out = r_data;

    // Result must not change while the downstream stalls it.
    a_out_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready) |=> $stable(state_out));

    // Idle and done are mutually exclusive.
    a_ready_valid_excl: assert property (@(posedge clk) disable iff (!rst_n)
        !(in_ready && out_valid));

    // Round index never drops below the p12 start while running.
    a_rnd_range: assert property (@(posedge clk) disable iff (!rst_n)
        (r_state == RUN) |-> (r_rnd >= P12_INIT));

endmodule

// File: doc/ascon_permutation.md
Name: ascon_permutation

Overview:
Iterative Ascon permutation engine. It applies one round per clock to the 320-bit state, using an internal round index of package type round. It runs p12 (P12_MODE) or p8 (P8_MODE) and sits between the AEAD128 control FSM (upstream, issues start/mode) and the state/data path (downstream, consumes the permuted state). One combinational round sub-module is instantiated; the round index sequencing is local.

Parameters:
None. All widths and constants come from ascon_aead128_pkg.

Ports:
clk        input   1    clock
rst_n      input   1    reset, asynchronous, active-low
in_valid   input   1    start request, state_in and mode are valid
in_ready   output  1    engine idle, accepts a request
mode       input   1    P12_MODE or P8_MODE, sampled on acceptance
state_in   input   320  x0=[319:256], x1=[255:192], x2=[191:128], x3=[127:64], x4=[63:0]
out_valid  output  1    state_out holds the permuted result
out_ready  input   1    downstream takes the result
state_out  output  320  result, same word mapping as state_in

Behaviour:
- Reset is asynchronous: FSM=IDLE, state register=0, rnd=P12_INIT. Outputs: in_ready=1, out_valid=0, state_out=0.
- FSM states IDLE, RUN, DONE. in_ready=(state==IDLE) and out_valid=(state==DONE); both decode registered state only.
- IDLE, in_valid=1:
  - Load state_in and set rnd = P12_INIT (4'h4) or P8_INIT (4'h8) from mode; go to RUN.
  - in_valid=0: hold.
- RUN, each cycle:
  - state <= round(state, rc(rnd)), then rnd <= rnd+1.
  - If rnd==4'hF this cycle, the round is the last one; go to DONE.
  - rnd is not incremented past 4'hF; it reloads on the next acceptance.
- DONE: state_out stable. out_valid&&out_ready -> IDLE. Stall indefinitely otherwise.
- Latency from accept edge to out_valid=1: 12 cycles (p12) or 8 cycles (p8). Back-to-back throughput is one permutation per 14/10 cycles.
- in_valid in RUN/DONE is ignored (in_ready=0). The upstream holds its request; no queuing.
- mode is sampled only on acceptance; mode changes during RUN have no effect.
- Round constant: j = rnd - 4, rc = {4'(15-j), 4'(j)}. rnd=4 -> 8'hF0, rnd=8 -> 8'hB4, rnd=15 -> 8'h4B.
- Round function, in this order:
  - Constant addition: x2 ^= {56'h0, rc}.
  - Substitution: 5-bit S-box per bit slice; input bit4=x0 .. bit0=x4. Table:
    04 0B 1F 14 1A 15 09 02 1B 05 08 12 1D 03 06 1C 1E 13 07 0E 00 0D 11 18 10 0C 01 19 16 0A 0F 17
  - Linear layer, right rotations:
    - x0 ^= ror19 ^ ror28
    - x1 ^= ror61 ^ ror39
    - x2 ^= ror1 ^ ror6
    - x3 ^= ror10 ^ ror17
    - x4 ^= ror7 ^ ror41
- Reset mid-RUN or mid-DONE aborts immediately; the partial state is discarded (register cleared to 0).
- SVA:
  - out_valid && !out_ready |=> $stable(state_out).
  - !(in_ready && out_valid).
  - rnd within 4..15 while in RUN.

Decomposition:
- ascon_aead128_pkg:
  - Existing: round (4-bit), P12_MODE/P8_MODE, P12_INIT/P8_INIT.
  - Add: ascon_state_t (5x64 packed), perm_state_e {IDLE,RUN,DONE}, function round_const(round) returning 8 bits, S-box table constant.
- Sub-module ascon_round: purely combinational, inputs state and rc, output next state. Reusable for unrolled variants.

Test Plan:
- Reset release, no stimulus -> in_ready=1, out_valid=0, state_out=0 held for 20 cycles.
- P12 request, state_in=0, out_ready=1 -> out_valid rises exactly 12 cycles after accept. Internal rc sequence is F0,E1,D2,C3,B4,A5,96,87,78,69,5A,4B. state_out equals the C reference model.
- P8 request, random state -> out_valid after 8 cycles. rc sequence is B4..4B. state_out matches the model.
- in_valid toggled and mode flipped during RUN, plus out_ready=0 for 5 cycles in DONE -> no extra accept, state_out stable, then IDLE on the handshake.
- rst_n pulsed low at round 5 of p12 -> outputs return to reset values asynchronously. The next p8 request completes correctly in 8 cycles.
- 1000 random back-to-back requests, mixed modes, random out_ready -> every result matches the model, none dropped or duplicated.
